seg7_scan_counter: RTL and testbench

- Parametrised successor of the single-digit seven-segment counter top.
- N-digit BCD up/down counter with prescaled stepping, synchronous load and a time-multiplexed seven-segment scan driver.
- Instantiated inside the tt_um top; drives uo_out[6:0] segments plus digit enables on uio_out.
- Single clock domain throughout.

---
 rtl/seg7_scan_counter.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down counter with prescaled stepping, synchronous load and a
// registered time-multiplexed seven-segment scan driver. Optional build macro:
// SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned SCAN_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  up_dn,
  input  logic                  pause,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  carry
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                hb_q, hb_d;
  logic                carry_q, carry_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;

  logic [4*DIGITS-1:0] inc_v, dec_v, sel_v;
  logic                inc_c, dec_b;
  logic [3:0]          nib;

  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Ripple increment/decrement; carry/borrow surviving the top digit flags a wrap.
  always_comb begin
    inc_v = cnt_q;
    dec_v = cnt_q;
    inc_c = 1'b1;
    dec_b = 1'b1;
    nib   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = cnt_q[4*i +: 4];
      if (inc_c) begin
        if (nib == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = nib + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (nib == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = nib - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  // sel_v is zero exactly when the selected digit and all higher digits are zero.
  assign sel_v = cnt_q >> {idx_q, 2'b00};

  always_comb begin
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    scan_d   = scan_q;
    idx_d    = idx_q;
    hb_d     = hb_q;
    carry_d  = carry_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    dig_en_d = dig_en_q;

    if (ena) begin
      carry_d = 1'b0;

      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        scan_d = scan_q + SW'(1);
      end

      dig_en_d = DIGITS'(1) << idx_q;
      dp_d     = (idx_q == '0) ? hb_q : 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      seg_d    = ((idx_q != '0) && (sel_v == '0)) ? 7'h00 : seg_enc(sel_v[3:0]);
`else
      seg_d    = seg_enc(sel_v[3:0]);
`endif

      if (load) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          cnt_d[4*i +: 4] = sat9(load_val[4*i +: 4]);
        end
        pre_d = '0;
      end else if (!pause) begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          hb_d  = ~hb_q;
          if (up_dn) begin
            cnt_d   = inc_v;
            carry_d = inc_c;
          end else begin
            cnt_d   = dec_v;
            carry_d = dec_b;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pre_q    <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      hb_q     <= 1'b0;
      carry_q  <= 1'b0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      dig_en_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      hb_q     <= hb_d;
      carry_q  <= carry_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_en  = dig_en_q;
  assign bcd_out = cnt_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: integer-valued reference model checked every
// cycle, plus directed load/wrap/pause/enable/reset and blanking scenarios.
module tb_seg7_scan_counter;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned SCAN_DIV = 2;
  localparam int unsigned W        = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n, ena, up_dn, pause, load;
  logic [W-1:0] load_val;
  logic [6:0]   seg;
  logic         dp, carry;
  logic [DIGITS-1:0] dig_en;
  logic [W-1:0] bcd_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up_dn(up_dn), .pause(pause),
    .load(load), .load_val(load_val), .seg(seg), .dp(dp), .dig_en(dig_en),
    .bcd_out(bcd_out), .carry(carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model (count held as a plain integer) ----------
  const logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    int n;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  int          m_cnt = 0, m_pre = 0, m_ecyc = 0, m_idx = 0;
  bit          m_hb = 1'b0, m_carry = 1'b0, m_dp = 1'b0;
  logic [6:0]  m_seg = '0;
  logic [DIGITS-1:0] m_dig = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_pre = 0; m_ecyc = 0; m_hb = 1'b0; m_carry = 1'b0;
      m_dp = 1'b0; m_seg = '0; m_dig = '0;
    end else if (ena) begin
      m_idx = (m_ecyc / int'(SCAN_DIV)) % int'(DIGITS);
      m_dig = DIGITS'(1) << m_idx;
      m_seg = SEGTAB[(m_cnt / pow10(m_idx)) % 10];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && m_cnt < pow10(m_idx)) m_seg = '0;
`endif
      m_dp = (m_idx == 0) ? m_hb : 1'b0;
      m_ecyc++;
      m_carry = 1'b0;
      if (load) begin
        m_cnt = bcd2int(load_val);
        m_pre = 0;
      end else if (!pause) begin
        if (m_pre == int'(PRESCALE) - 1) begin
          m_pre = 0;
          m_hb  = !m_hb;
          if (up_dn) begin
            if (m_cnt == pow10(DIGITS) - 1) begin m_cnt = 0; m_carry = 1'b1; end
            else m_cnt++;
          end else begin
            if (m_cnt == 0) begin m_cnt = pow10(DIGITS) - 1; m_carry = 1'b1; end
            else m_cnt--;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("mdl_dig_en", 32'(dig_en), 32'(m_dig));
    chk("mdl_seg", 32'(seg), 32'(m_seg));
    chk("mdl_dp", 32'(dp), 32'(m_dp));
    chk("mdl_bcd", 32'(bcd_out), 32'(int2bcd(m_cnt)));
    chk("mdl_carry", 32'(carry), 32'(m_carry));
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Wider instance for the leading-zero blanking scenario.
  logic        ld2;
  logic [15:0] lv2, bcd2;
  logic [6:0]  seg2;
  logic        dp2, carry2;
  logic [3:0]  dig2;
  bit          found;
  logic [6:0]  exp42 [4] = '{7'h5B, 7'h66, 7'h00, 7'h00};

  seg7_scan_counter #(.DIGITS(4), .PRESCALE(4), .SCAN_DIV(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .up_dn(1'b1), .pause(1'b1),
    .load(ld2), .load_val(lv2), .seg(seg2), .dp(dp2), .dig_en(dig2),
    .bcd_out(bcd2), .carry(carry2)
  );

  task automatic wait_dig2(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (dig2 == want) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask
`endif

  // ---------------- directed stimulus ---------------------------------------
  initial begin
    rst_n = 1'b1; ena = 1'b0; up_dn = 1'b1; pause = 1'b0; load = 1'b0; load_val = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ld2 = 1'b0; lv2 = '0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'h0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    rst_n = 1'b1;
    tick();
    ena = 1'b1;
    tick();
    chk("first_dig_en", 32'(dig_en), 32'h1);
    chk("first_seg", 32'(seg), 32'h3F);
    chk("first_bcd", 32'(bcd_out), 32'h00);
    chk("first_carry", 32'(carry), 32'h0);

    load = 1'b1; load_val = 8'h98;
    tick();
    load = 1'b0;
    chk("load98", 32'(bcd_out), 32'h98);
    repeat (3) tick();
    chk("pre_hold98", 32'(bcd_out), 32'h98);
    tick();
    chk("step_99", 32'(bcd_out), 32'h99);
    chk("step_99_carry", 32'(carry), 32'h0);
    repeat (3) tick();
    chk("pre_hold99", 32'(bcd_out), 32'h99);
    tick();
    chk("wrap_up_bcd", 32'(bcd_out), 32'h00);
    chk("wrap_up_carry", 32'(carry), 32'h1);
    tick();
    chk("carry_one_clk", 32'(carry), 32'h0);

    up_dn = 1'b0;
    repeat (2) tick();
    chk("pre_hold00", 32'(bcd_out), 32'h00);
    tick();
    chk("wrap_dn_bcd", 32'(bcd_out), 32'h99);
    chk("wrap_dn_carry", 32'(carry), 32'h1);

    load = 1'b1; load_val = 8'hA3;
    tick();
    load = 1'b0;
    chk("load_sat_A3", 32'(bcd_out), 32'h93);
    chk("load_carry", 32'(carry), 32'h0);

    pause = 1'b1; load = 1'b1; load_val = 8'h5F;
    tick();
    load = 1'b0;
    chk("load_in_pause", 32'(bcd_out), 32'h59);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("pause_frozen", 32'(bcd_out), 32'h59);
    end
    pause = 1'b0; ena = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ena_frozen", 32'(bcd_out), 32'h59);
    end
    ena = 1'b1;

    repeat (3) tick();
    chk("pre_hold59", 32'(bcd_out), 32'h59);
    load = 1'b1; load_val = 8'h25;
    tick();
    load = 1'b0;
    chk("load_beats_step", 32'(bcd_out), 32'h25);
    repeat (3) tick();
    chk("no_early_step", 32'(bcd_out), 32'h25);
    tick();
    chk("step_after_load", 32'(bcd_out), 32'h24);

    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg), 32'h0);
    chk("midrst_dig_en", 32'(dig_en), 32'h0);
    chk("midrst_bcd", 32'(bcd_out), 32'h0);
    chk("midrst_dp", 32'(dp), 32'h0);
    chk("midrst_carry", 32'(carry), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("resume_dig_en", 32'(dig_en), 32'h1);
    chk("resume_seg", 32'(seg), 32'h3F);
    chk("resume_bcd", 32'(bcd_out), 32'h00);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    ld2 = 1'b1; lv2 = 16'h0042;
    tick();
    ld2 = 1'b0;
    chk("blank_load", 32'(bcd2), 32'h0042);
    tick();
    for (int d = 0; d < 4; d++) begin
      wait_dig2(4'(1 << d), found);
      chk("blank_dig_found", 32'(found), 32'h1);
      chk("blank_seg_0042", 32'(seg2), 32'(exp42[d]));
    end
    ld2 = 1'b1; lv2 = 16'h0000;
    tick();
    ld2 = 1'b0;
    tick();
    wait_dig2(4'b0001, found);
    chk("zero_dig_found", 32'(found), 32'h1);
    chk("zero_digit0", 32'(seg2), 32'h3F);
    wait_dig2(4'b0010, found);
    chk("zero_dig1_found", 32'(found), 32'h1);
    chk("zero_digit1_blank", 32'(seg2), 32'h00);
`endif

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
